// File: rtl/mem_loader_pkg.sv
// Shared types and widths for the data-memory preload engine.
package mem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned IDX_W          = 2;
    localparam int unsigned COUNT_W        = 11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/mem_loader_byte_packer.sv
// Little-endian byte packer: byte k of a word lands in bits [8k+7:8k].
module byte_packer
    import mem_loader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                accept,
    input  logic [BYTE_W-1:0]   byteIn,
    output logic [WORD_W-1:0]   word,
    output logic                wordFull_c
);

    logic [IDX_W-1:0] byteIdx;

    // Accepting into the last lane completes the word this cycle.
    assign wordFull_c = accept && (byteIdx == IDX_W'(BYTES_PER_WORD - 1));

    // Lane index and insert register; the index wraps to lane 0 after a full word.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byteIdx <= '0;
            word    <= '0;
        end else if (accept) begin
            byteIdx                       <= byteIdx + IDX_W'(1);
            word[BYTE_W*byteIdx +: BYTE_W] <= byteIn;
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Preload engine: packs a byte stream into words, writes them to data memory
// through the external write port and holds the CPU in reset until done.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned NUM_WORDS = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    output logic         byte_ready,
    output logic         Ext_MemWrite,
    output logic [31:0]  Ext_DataAdr,
    output logic [31:0]  Ext_WriteData,
    output logic         cpu_reset,
    output logic         busy,
    output logic         done,
    output logic [10:0]  word_count
);

    state_e               state;
    state_e               stateNext;
    logic [WORD_W-1:0]    addrReg;
    logic [WORD_W-1:0]    addrNext;
    logic [COUNT_W-1:0]   countNext;
    logic [WORD_W-1:0]    adrOutNext;
    logic [WORD_W-1:0]    dataOutNext;
    logic                 clearPack;
    logic                 accept;
    logic                 wordFull_c;
    logic [WORD_W-1:0]    packWord;

    // The source may only transfer while collecting; bytes offered during WRITE wait.
    assign byte_ready = (state == COLLECT);
    assign accept     = byte_valid && byte_ready;

    byte_packer uPacker (
        .clk        (clk),
        .reset      (reset),
        .clear      (clearPack),
        .accept     (accept),
        .byteIn     (byte_in),
        .word       (packWord),
        .wordFull_c (wordFull_c)
    );

    // Next-state and next-value decode for the FSM and its datapath registers.
    always_comb begin
        stateNext   = state;
        addrNext    = addrReg;
        countNext   = word_count;
        adrOutNext  = Ext_DataAdr;
        dataOutNext = Ext_WriteData;
        clearPack   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    stateNext = COLLECT;
                    addrNext  = BASE_ADDR;
                    countNext = '0;
                    clearPack = 1'b1;
                end
            end
            COLLECT: begin
                if (wordFull_c) begin
                    // The top byte is still on byte_in; merge it with the three packed lanes.
                    stateNext   = WRITE;
                    adrOutNext  = addrReg;
                    dataOutNext = {byte_in, packWord[WORD_W-BYTE_W-1:0]};
                end
            end
            WRITE: begin
                countNext = word_count + COUNT_W'(1);
                addrNext  = addrReg + WORD_W'(BYTES_PER_WORD);
                stateNext = (countNext == COUNT_W'(NUM_WORDS)) ? DONE : COLLECT;
            end
            default: stateNext = IDLE;
        endcase
    end

    // State, datapath and registered outputs, all derived from the decoded next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            addrReg       <= BASE_ADDR;
            word_count    <= '0;
            Ext_MemWrite  <= 1'b0;
            Ext_DataAdr   <= BASE_ADDR;
            Ext_WriteData <= '0;
            cpu_reset     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= stateNext;
            addrReg       <= addrNext;
            word_count    <= countNext;
            Ext_MemWrite  <= (stateNext == WRITE);
            Ext_DataAdr   <= adrOutNext;
            Ext_WriteData <= dataOutNext;
            cpu_reset     <= (stateNext != DONE);
            busy          <= (stateNext == COLLECT) || (stateNext == WRITE);
            done          <= (stateNext == DONE);
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Randomized bench for mem_loader: three instances with different word counts
// and base addresses, checked against a byte-stream-to-write-list model.
module tb_mem_loader;

    logic        clk;
    logic        rst   [3];
    logic        st    [3];
    logic [7:0]  bi    [3];
    logic        bv    [3];
    logic        br    [3];
    logic        mw    [3];
    logic [31:0] adr   [3];
    logic [31:0] wd    [3];
    logic        cr    [3];
    logic        bz    [3];
    logic        dn    [3];
    logic [10:0] wc    [3];

    int vectors;
    int miscompares;

    typedef struct {
        int          u;
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t        wrLog [$];
    logic [7:0] stream[$];

    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0000_0040;
    localparam logic [31:0] BASE2 = 32'h0000_0100;

    mem_loader #(.BASE_ADDR(BASE0), .NUM_WORDS(1)) dut0 (
        .clk(clk), .reset(rst[0]), .start(st[0]), .byte_in(bi[0]), .byte_valid(bv[0]),
        .byte_ready(br[0]), .Ext_MemWrite(mw[0]), .Ext_DataAdr(adr[0]), .Ext_WriteData(wd[0]),
        .cpu_reset(cr[0]), .busy(bz[0]), .done(dn[0]), .word_count(wc[0]));

    mem_loader #(.BASE_ADDR(BASE1), .NUM_WORDS(3)) dut1 (
        .clk(clk), .reset(rst[1]), .start(st[1]), .byte_in(bi[1]), .byte_valid(bv[1]),
        .byte_ready(br[1]), .Ext_MemWrite(mw[1]), .Ext_DataAdr(adr[1]), .Ext_WriteData(wd[1]),
        .cpu_reset(cr[1]), .busy(bz[1]), .done(dn[1]), .word_count(wc[1]));

    mem_loader #(.BASE_ADDR(BASE2), .NUM_WORDS(2)) dut2 (
        .clk(clk), .reset(rst[2]), .start(st[2]), .byte_in(bi[2]), .byte_valid(bv[2]),
        .byte_ready(br[2]), .Ext_MemWrite(mw[2]), .Ext_DataAdr(adr[2]), .Ext_WriteData(wd[2]),
        .cpu_reset(cr[2]), .busy(bz[2]), .done(dn[2]), .word_count(wc[2]));

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Log every write strobe; ready must be low while a write is in flight.
    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (mw[u] === 1'b1) begin
                wrLog.push_back('{u: u, a: adr[u], d: wd[u]});
                checkVal("readyInWrite", 32'(br[u]), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart(input int u);
        st[u] = 1'b1;
        tick();
        st[u] = 1'b0;
    endtask

    // Offer one byte, optionally after random idle cycles, and hold it until taken.
    task automatic sendByte(input int u, input logic [7:0] b, input int bubbleMax);
        int n;
        bit taken;
        n = (bubbleMax > 0) ? int'($urandom_range(bubbleMax, 0)) : 0;
        repeat (n) begin
            bv[u] = 1'b0;
            tick();
        end
        bi[u] = b;
        bv[u] = 1'b1;
        taken = 1'b0;
        for (int i = 0; i < 50 && !taken; i++) begin
            taken = br[u];
            tick();
        end
        if (!taken) checkVal("byteTimeout", 32'd0, 32'd1);
    endtask

    task automatic sendRange(input int u, input int from, input int to, input int bubbleMax);
        for (int i = from; i < to; i++) sendByte(u, stream[i], bubbleMax);
        bv[u] = 1'b0;
    endtask

    task automatic newStream(input int n);
        stream.delete();
        for (int i = 0; i < n; i++) stream.push_back(8'($urandom));
    endtask

    task automatic waitDone(input int u);
        int i;
        i = 0;
        while (dn[u] !== 1'b1 && i < 200) begin
            tick();
            i++;
        end
        checkVal("doneReached", 32'(dn[u]), 32'd1);
    endtask

    task automatic clearLog(input int u);
        wr_t keep[$];
        foreach (wrLog[i]) if (wrLog[i].u != u) keep.push_back(wrLog[i]);
        wrLog = keep;
    endtask

    // Model: word i goes to base+4i and holds stream bytes 4i..4i+3, lowest byte first.
    task automatic compareWrites(input int u, input logic [31:0] base, input int nWords);
        wr_t got[$];
        logic [31:0] expD;
        foreach (wrLog[i]) if (wrLog[i].u == u) got.push_back(wrLog[i]);
        checkVal("writeCount", 32'(got.size()), 32'(nWords));
        for (int i = 0; i < nWords && i < got.size(); i++) begin
            expD = 32'(stream[4*i]) + (32'(stream[4*i+1]) << 8)
                 + (32'(stream[4*i+2]) << 16) + (32'(stream[4*i+3]) << 24);
            checkVal("writeAddr", got[i].a, base + 32'(4 * i));
            checkVal("writeData", got[i].d, expD);
        end
    endtask

    function automatic int countWrites(input int u);
        int n;
        n = 0;
        foreach (wrLog[i]) if (wrLog[i].u == u) n++;
        return n;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int u = 0; u < 3; u++) begin
            rst[u] = 1'b1;
            st[u]  = 1'b0;
            bi[u]  = 8'h00;
            bv[u]  = 1'b0;
        end

        // Reset held three cycles, then idle with no start.
        repeat (3) tick();
        for (int u = 0; u < 3; u++) rst[u] = 1'b0;
        repeat (3) tick();
        checkVal("rstCpuReset", 32'(cr[0]), 32'd1);
        checkVal("rstReady",    32'(br[0]), 32'd0);
        checkVal("rstMemWrite", 32'(mw[0]), 32'd0);
        checkVal("rstDone",     32'(dn[0]), 32'd0);
        checkVal("rstBusy",     32'(bz[0]), 32'd0);
        checkVal("rstCount",    32'(wc[0]), 32'd0);
        checkVal("rstAdr",      adr[1],     BASE1);
        checkVal("rstData",     wd[1],      32'd0);

        // Single word, bytes back-to-back.
        stream = '{8'h78, 8'h56, 8'h34, 8'h12};
        pulseStart(0);
        checkVal("startBusy", 32'(bz[0]), 32'd1);
        checkVal("startReady", 32'(br[0]), 32'd1);
        sendRange(0, 0, 4, 0);
        checkVal("oneMemWrite", 32'(mw[0]), 32'd1);
        checkVal("oneAdr",      adr[0],     32'h0);
        checkVal("oneData",     wd[0],      32'h1234_5678);
        checkVal("oneReadyLow", 32'(br[0]), 32'd0);
        checkVal("oneNotDone",  32'(dn[0]), 32'd0);
        tick();
        checkVal("oneDone",     32'(dn[0]), 32'd1);
        checkVal("oneCpuRst",   32'(cr[0]), 32'd0);
        checkVal("oneCount",    32'(wc[0]), 32'd1);
        checkVal("oneBusy",     32'(bz[0]), 32'd0);
        checkVal("oneStrobe",   32'(mw[0]), 32'd0);
        repeat (3) tick();
        compareWrites(0, BASE0, 1);

        // Three words with random valid bubbles.
        newStream(12);
        pulseStart(1);
        sendRange(1, 0, 12, 3);
        waitDone(1);
        checkVal("multiCount",  32'(wc[1]), 32'd3);
        checkVal("multiCpuRst", 32'(cr[1]), 32'd0);
        compareWrites(1, BASE1, 3);

        // Reset after two bytes of the second word.
        newStream(6);
        pulseStart(2);
        sendRange(2, 0, 6, 2);
        tick();
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0;
        checkVal("midCpuRst", 32'(cr[2]), 32'd1);
        checkVal("midBusy",   32'(bz[2]), 32'd0);
        checkVal("midReady",  32'(br[2]), 32'd0);
        checkVal("midCount",  32'(wc[2]), 32'd0);
        checkVal("midAdr",    adr[2],     BASE2);
        repeat (4) tick();
        checkVal("midWrites", 32'(countWrites(2)), 32'd1);
        clearLog(2);
        newStream(8);
        pulseStart(2);
        sendRange(2, 0, 8, 2);
        waitDone(2);
        checkVal("restartCount", 32'(wc[2]), 32'd2);
        compareWrites(2, BASE2, 2);

        // Reload from DONE with stray start pulses while busy.
        clearLog(1);
        newStream(12);
        pulseStart(1);
        checkVal("reloadCpuRst", 32'(cr[1]), 32'd1);
        checkVal("reloadCount",  32'(wc[1]), 32'd0);
        checkVal("reloadDone",   32'(dn[1]), 32'd0);
        checkVal("reloadBusy",   32'(bz[1]), 32'd1);
        sendRange(1, 0, 2, 1);
        pulseStart(1);
        tick();
        checkVal("ignoreBusy",  32'(bz[1]), 32'd1);
        checkVal("ignoreCount", 32'(wc[1]), 32'd0);
        sendRange(1, 2, 6, 1);
        repeat (2) tick();
        pulseStart(1);
        checkVal("ignoreCount2", 32'(wc[1]), 32'd1);
        sendRange(1, 6, 12, 2);
        waitDone(1);
        checkVal("reloadFinal", 32'(wc[1]), 32'd3);
        compareWrites(1, BASE1, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
# mem_loader

Preload engine for the data memory of the single-cycle RV32 test top. Accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit words and issues one external write per word on the memory's external write port (Ext_MemWrite / Ext_DataAdr / Ext_WriteData). It holds the CPU in reset while loading and releases it once the programmed word count has been written.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word-aligned.
- NUM_WORDS, 64, number of words per load; 1..1024.

Ports:
- clk  input  1  system clock; the block has one clock.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1  begins a load; honoured only in IDLE or DONE.
- byte_in  input  8  stream data.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- Ext_MemWrite  output  1  one-cycle write strobe to data memory.
- Ext_DataAdr  output  32  byte address of the write.
- Ext_WriteData  output  32  packed word.
- cpu_reset  output  1  reset to the CPU/top; high while not DONE.
- busy  output  1  high in COLLECT or WRITE.
- done  output  1  high in DONE.
- word_count  output  11  words written in the current load.

## Operation
- FSM states: IDLE, COLLECT, WRITE, DONE. All outputs are registered except byte_ready, which is decoded from the state (high only in COLLECT).
- IDLE: start=1 -> COLLECT. Clears word_count, byte index and address to BASE_ADDR.
- COLLECT: a byte transfers on byte_valid && byte_ready.
  - Byte k (0..3) lands in bits [8k+7:8k] of the packing register (little-endian).
  - The 4th accepted byte moves the FSM to WRITE.
- WRITE (exactly one cycle): Ext_MemWrite=1, Ext_DataAdr = BASE_ADDR + 4*word_count, Ext_WriteData = packed word.
  - Next cycle: word_count increments.
  - If the new word_count equals NUM_WORDS -> DONE; otherwise -> COLLECT with address +4.
- DONE: cpu_reset=0 and done=1.
  - start=1 -> COLLECT for a fresh load; cpu_reset returns high in the same transition, and the counters and address are cleared.
- start is ignored in COLLECT and WRITE.
- Ext_DataAdr and Ext_WriteData hold their last values when Ext_MemWrite=0. Ext_MemWrite is never high outside WRITE.
- Address arithmetic is 32-bit unsigned and wraps modulo 2^32 without a flag.

## Timing
- Reset values:
  - state = IDLE.
  - Ext_MemWrite, busy, done and word_count = 0.
  - Ext_DataAdr = BASE_ADDR, Ext_WriteData = 0.
  - cpu_reset = 1; byte_ready = 0.
- Latency: the 4th byte is accepted at edge N; Ext_MemWrite is high during cycle N+1. word_count is updated and byte_ready is high again in cycle N+2. Each word therefore costs at least 5 cycles.
- byte_valid may stay high continuously. A byte presented during WRITE is not consumed and must be held by the source.
- DONE is entered on the edge after the last WRITE cycle. cpu_reset falls and done rises on that same edge.
- Reset mid-load: the next edge returns the block to the reset values. The partial word is discarded and cpu_reset goes high. Words already written stay in memory.
- reset has priority over start and byte_valid in the same cycle.
- NUM_WORDS=1: sequence is IDLE -> COLLECT -> WRITE -> DONE.

## Structure
- Package mem_loader_pkg holds:
  - the state enum (IDLE, COLLECT, WRITE, DONE);
  - BYTES_PER_WORD = 4;
  - WORD_W = 32.
- One sub-module, byte_packer: a 2-bit byte index plus a 32-bit shift/insert register.
  - Inputs: clear and accept.
  - Outputs: word and word_full.
- The top-level FSM, address register and word counter stay in mem_loader.
- Integration: cpu_reset drives the test top's reset; the Ext_* outputs drive its Ext_* inputs.

## Test plan
- Reset then idle: hold reset 3 cycles, release.
  - Required: cpu_reset=1, byte_ready=0, Ext_MemWrite=0, done=0 with no start.
- Single word (NUM_WORDS=1, BASE_ADDR=0): start, then bytes 8'h78, 8'h56, 8'h34, 8'h12 back-to-back.
  - Required: exactly one Ext_MemWrite pulse with Ext_DataAdr=0 and Ext_WriteData=32'h1234_5678.
  - Then done=1 and cpu_reset=0 on the following edge.
- Multi-word with gaps (NUM_WORDS=3, BASE_ADDR=32'h40): random byte_valid bubbles.
  - Required: writes at 0x40, 0x44 and 0x48 with the correct words.
  - byte_ready=0 during each WRITE cycle; no byte is lost or duplicated; word_count reaches 3.
- Reset mid-word: assert reset after 2 bytes of word 1 (NUM_WORDS=2).
  - Required: no Ext_MemWrite for the partial word, state back to IDLE, cpu_reset=1.
  - A restart then loads both words from BASE_ADDR.
- Start ignored while busy, then reload from DONE: pulse start during COLLECT.
  - Required: no effect while busy.
  - After DONE, a start drives cpu_reset=1 and word_count=0, and a second load writes again from BASE_ADDR.
